rename_free_list: RTL and testbench

RENAME_FREE_LIST -- requirements
Module: rename_free_list

---
 rtl/rename_free_list.sv | 74 +++++++
 tb/tb_rename_free_list.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rename_free_list.sv
// Physical register free list: circular queue of free pregs with a
// single branch checkpoint on the allocation pointer.
module rename_free_list #(
    parameter int NUM_PREG = 64,
    parameter int NUM_AREG = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alloc_req,
    output logic       alloc_grant,
    output logic [5:0] alloc_preg,
    input  logic       free_valid,
    input  logic [5:0] free_preg,
    input  logic       ckpt_save,
    input  logic       ckpt_restore,
    output logic [6:0] free_count,
    output logic       empty,
    output logic       overflow_err
);

    localparam int NUM_INIT = NUM_PREG - NUM_AREG;

    logic [5:0] queue [64];
    logic [6:0] head;
    logic [6:0] tail;
    logic [6:0] ckpt_head;
    logic [6:0] head_next;
    logic       full;
    logic       free_ok;
    logic       free_drop;

    assign free_count  = tail - head;
    assign empty       = (tail == head);
    assign full        = (tail[6] != head[6]) && (tail[5:0] == head[5:0]);
    assign alloc_preg  = queue[head[5:0]];
    assign alloc_grant = alloc_req && !empty && !ckpt_restore;

    // p0 is the hardwired zero register and never enters the list
    assign free_ok   = free_valid && (free_preg != 6'd0) && !full;
    assign free_drop = free_valid && (free_preg != 6'd0) && full;

    always_comb begin
        head_next = head + {6'd0, alloc_grant};
        if (ckpt_restore) begin
            head_next = ckpt_head;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                queue[i] <= (i < NUM_INIT) ? 6'(NUM_AREG + i) : 6'd0;
            end
            head         <= 7'd0;
            tail         <= 7'(NUM_INIT);
            ckpt_head    <= 7'd0;
            overflow_err <= 1'b0;
        end else begin
            if (free_ok) begin
                queue[tail[5:0]] <= free_preg;
                tail             <= tail + 7'd1;
            end
            if (free_drop) begin
                overflow_err <= 1'b1;
            end
            head <= head_next;
            // restore wins over save, so the snapshot tracks the restored head
            if (ckpt_restore || ckpt_save) begin
                ckpt_head <= head_next;
            end
        end
    end

endmodule

// File: tb/tb_rename_free_list.sv
// Directed bench for rename_free_list with an unbounded-pointer
// reference model checked on every falling edge.
module tb_rename_free_list;

    logic       clk;
    logic       rst;
    logic       alloc_req;
    logic       alloc_grant;
    logic [5:0] alloc_preg;
    logic       free_valid;
    logic [5:0] free_preg;
    logic       ckpt_save;
    logic       ckpt_restore;
    logic [6:0] free_count;
    logic       empty;
    logic       overflow_err;

    rename_free_list #(.NUM_PREG(64), .NUM_AREG(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_req    (alloc_req),
        .alloc_grant  (alloc_grant),
        .alloc_preg   (alloc_preg),
        .free_valid   (free_valid),
        .free_preg    (free_preg),
        .ckpt_save    (ckpt_save),
        .ckpt_restore (ckpt_restore),
        .free_count   (free_count),
        .empty        (empty),
        .overflow_err (overflow_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: pointers are plain unbounded integers, the list
    // is a 64-slot ring indexed modulo 64, occupancy is their difference.
    int mq [64];
    int mh;
    int mt;
    int mck;
    bit merr;
    bit mvalid = 1'b0;

    function automatic int m_count();
        return mt - mh;
    endfunction

    function automatic bit m_grant();
        return alloc_req && (m_count() > 0) && !ckpt_restore;
    endfunction

    function automatic int m_head_reg();
        return mq[mh % 64];
    endfunction

    always @(posedge clk) begin
        int nh;
        if (rst) begin
            for (int i = 0; i < 32; i++) mq[i] = 32 + i;
            mh     = 0;
            mt     = 32;
            mck    = 0;
            merr   = 1'b0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            nh = ckpt_restore ? mck : mh + int'(m_grant());
            if (free_valid && free_preg != 6'd0) begin
                if (m_count() < 64) begin
                    mq[mt % 64] = int'(free_preg);
                    mt++;
                end else begin
                    merr = 1'b1;
                end
            end
            if (ckpt_restore || ckpt_save) mck = nh;
            mh = nh;
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("m_count", int'(free_count), m_count());
            chk("m_empty", int'(empty), int'(m_count() == 0));
            chk("m_grant", int'(alloc_grant), int'(m_grant()));
            chk("m_err", int'(overflow_err), int'(merr));
            if (m_count() > 0) chk("m_preg", int'(alloc_preg), m_head_reg());
        end
    end

    logic       last_grant;
    logic [5:0] last_preg;

    // One clock: apply inputs, sample the combinational outputs mid-cycle,
    // then return just after the rising edge with state updated.
    task automatic cyc(input logic r, input logic req, input logic fv,
                       input logic [5:0] fp, input logic sv, input logic rs);
        rst          = r;
        alloc_req    = req;
        free_valid   = fv;
        free_preg    = fp;
        ckpt_save    = sv;
        ckpt_restore = rs;
        @(negedge clk);
        #1;
        last_grant = alloc_grant;
        last_preg  = alloc_preg;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        alloc_req    = 1'b0;
        free_valid   = 1'b0;
        free_preg    = 6'd0;
        ckpt_save    = 1'b0;
        ckpt_restore = 1'b0;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b1, 1'b1, 6'd9, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0; alloc_req = 1'b0; free_valid = 1'b0;
        free_preg = 6'd0; ckpt_save = 1'b0; ckpt_restore = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        chk("rst_count", int'(free_count), 32);
        chk("rst_empty", int'(empty), 0);
        chk("rst_preg", int'(alloc_preg), 32);
        chk("rst_err", int'(overflow_err), 0);

        // drain the list
        for (int i = 0; i < 32; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
            chk("drain_grant", int'(last_grant), 1);
            chk("drain_preg", int'(last_preg), 32 + i);
        end
        chk("drain_count", int'(free_count), 0);
        chk("drain_empty", int'(empty), 1);
        cyc(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        chk("req33_grant", int'(last_grant), 0);

        // free while empty: no bypass
        cyc(1'b0, 1'b1, 1'b1, 6'd5, 1'b0, 1'b0);
        chk("nobypass_grant", int'(last_grant), 0);
        chk("nobypass_count", int'(free_count), 1);
        chk("nobypass_preg", int'(alloc_preg), 5);
        cyc(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        chk("p5_grant", int'(last_grant), 1);
        chk("p5_preg", int'(last_preg), 5);

        // checkpoint then roll back three allocations
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
            chk("ck_preg", int'(last_preg), 32 + i);
        end
        chk("ck_mid_count", int'(free_count), 29);
        cyc(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1);
        chk("restore_grant", int'(last_grant), 0);
        chk("restore_count", int'(free_count), 32);
        chk("restore_preg", int'(alloc_preg), 32);

        // save in the same cycle as a grant captures the advanced head
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
        chk("save_grant_preg", int'(alloc_preg), 33);

        // p0 ignored, then overflow on the 33rd free
        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0);
        chk("p0_count", int'(free_count), 32);
        for (int i = 1; i <= 32; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 6'(i), 1'b0, 1'b0);
        end
        chk("full_count", int'(free_count), 64);
        chk("full_err", int'(overflow_err), 0);
        cyc(1'b0, 1'b0, 1'b1, 6'd33, 1'b0, 1'b0);
        chk("ovf_count", int'(free_count), 64);
        chk("ovf_err", int'(overflow_err), 1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        chk("ovf_sticky", int'(overflow_err), 1);
        chk("ovf_after_preg", int'(last_preg), 34);
        do_reset();
        chk("ovf_cleared", int'(overflow_err), 0);

        // steady alloc+free recycling, tail wraps past 127
        for (int i = 0; i < 100; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 6'(m_head_reg()), 1'b0, 1'b0);
            if (last_grant !== 1'b1 || free_count !== 7'd32) begin
                chk("cycle_grant", int'(last_grant), 1);
                chk("cycle_count", int'(free_count), 32);
            end
        end
        chk("cycle_end_count", int'(free_count), 32);
        chk("cycle_end_preg", int'(alloc_preg), 32 + (100 % 32));

        // save and restore together, then re-restore
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b1);
        chk("both_preg", int'(alloc_preg), 34);
        cyc(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        chk("both_adv_preg", int'(alloc_preg), 36);
        cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
        chk("both_back_preg", int'(alloc_preg), 34);
        chk("both_back_count", int'(free_count), 30);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
